// File: rtl/debounce_event.sv
// Multi-channel debouncer producing levels plus rise/fall, long-press and auto-repeat events.
// All channels share one sample prescaler; every output is registered.
module debounce_event #(
    parameter int unsigned      WIDTH        = 8,
    parameter int unsigned      N            = 4,
    parameter int unsigned      RATE         = 125000,
    parameter int unsigned      HOLD_TICKS   = 250,
    parameter int unsigned      REPEAT_TICKS = 0,
    parameter logic [WIDTH-1:0] ACTIVE_LOW   = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] out_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] hold_o,
    output logic [WIDTH-1:0] hold_pulse_o,
    output logic             sample_tick_o
);

    localparam int unsigned PW = (RATE > 1) ? $clog2(RATE) : 1;
    localparam int unsigned HW = (HOLD_TICKS >= 1) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam int unsigned RW = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;

    localparam logic [PW-1:0] PMax = PW'((RATE > 0) ? RATE - 1 : 0);
    localparam logic [HW-1:0] HMax = HW'(HOLD_TICKS);
    localparam logic [RW-1:0] RMax = RW'(REPEAT_TICKS);

    if (N < 2) begin : g_bad_n
        $error("debounce_event: N must be >= 2");
    end
    if (RATE < 1) begin : g_bad_rate
        $error("debounce_event: RATE must be >= 1");
    end
    if (HOLD_TICKS < 1) begin : g_bad_hold
        $error("debounce_event: HOLD_TICKS must be >= 1");
    end

    // Prescaler; tick_q is high in the cycle the count sits at RATE-1.
    logic [PW-1:0] pre_q, pre_d;
    logic          tick_q, tick_d;

    always_comb begin
        pre_d  = (pre_q == PMax) ? '0 : pre_q + 1'b1;
        tick_d = (pre_d == PMax);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end

    assign sample_tick_o = tick_q;

    // Polarity applied ahead of the synchroniser so everything downstream is active-high.
    logic [WIDTH-1:0] s1_q, s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= in_i ^ ACTIVE_LOW;
            s2_q <= s1_q;
        end
    end

    for (genvar c = 0; c < WIDTH; c++) begin : g_ch
        logic [N-2:0]  hist_q, hist_d;
        logic [N-1:0]  hist_nx;
        logic          out_q, out_d;
        logic          rise_q, rise_d;
        logic          fall_q, fall_d;
        logic          hold_q, hold_d;
        logic          hp_q, hp_d;
        logic [HW-1:0] hcnt_q, hcnt_d;
        logic [RW-1:0] rcnt_q, rcnt_d;

        always_comb begin
            hist_nx = {hist_q, s2_q[c]};
            hist_d  = hist_q;
            out_d   = out_q;
            hold_d  = hold_q;
            hcnt_d  = hcnt_q;
            rcnt_d  = rcnt_q;
            hp_d    = 1'b0;

            if (tick_q) begin
                hist_d = hist_nx[N-2:0];
                if (&hist_nx) begin
                    out_d = 1'b1;
                end else if (~|hist_nx) begin
                    out_d = 1'b0;
                end

                // Only count while the level stays high across this tick; a fall wins.
                if (out_q && out_d) begin
                    if (hold_q) begin
                        if (REPEAT_TICKS != 0) begin
                            rcnt_d = rcnt_q + 1'b1;
                            if (rcnt_d == RMax) begin
                                hp_d   = 1'b1;
                                rcnt_d = '0;
                            end
                        end
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                        if (hcnt_d == HMax) begin
                            hold_d = 1'b1;
                            hp_d   = 1'b1;
                        end
                    end
                end
            end

            if (!out_d) begin
                hold_d = 1'b0;
                hcnt_d = '0;
                rcnt_d = '0;
            end

            rise_d = out_d & ~out_q;
            fall_d = out_q & ~out_d;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hist_q <= '0;
                out_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                hold_q <= 1'b0;
                hp_q   <= 1'b0;
                hcnt_q <= '0;
                rcnt_q <= '0;
            end else begin
                hist_q <= hist_d;
                out_q  <= out_d;
                rise_q <= rise_d;
                fall_q <= fall_d;
                hold_q <= hold_d;
                hp_q   <= hp_d;
                hcnt_q <= hcnt_d;
                rcnt_q <= rcnt_d;
            end
        end

        assign out_o[c]        = out_q;
        assign rise_o[c]       = rise_q;
        assign fall_o[c]       = fall_q;
        assign hold_o[c]       = hold_q;
        assign hold_pulse_o[c] = hp_q;
    end

endmodule

// File: tb/tb_debounce_event.sv
// Scoreboard bench for debounce_event: two instances with different parameter sets.
// Stimulus queues expected events; per-instance monitors pop them whenever a pulse appears.
module tb_debounce_event;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  rise;
        logic [7:0]  fall;
        logic [7:0]  hp;
        logic [7:0]  out;
        logic [7:0]  hold;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_a, in_b;
    logic [7:0] out_a, rise_a, fall_a, hold_a, hp_a;
    logic [7:0] out_b, rise_b, fall_b, hold_b, hp_b;
    logic       tick_a, tick_b;

    int  cyc   = 0;
    int  tests = 0;
    int  fails = 0;
    ev_t qa[$];
    ev_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A: fast sampling with long-press and auto-repeat, channel 0 active-low.
    debounce_event #(
        .WIDTH(8), .N(4), .RATE(1), .HOLD_TICKS(2), .REPEAT_TICKS(2), .ACTIVE_LOW(8'h01)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_i(in_a), .out_o(out_a), .rise_o(rise_a),
        .fall_o(fall_a), .hold_o(hold_a), .hold_pulse_o(hp_a), .sample_tick_o(tick_a)
    );

    // B: prescaled sampling, long-press without repeat.
    debounce_event #(
        .WIDTH(8), .N(4), .RATE(4), .HOLD_TICKS(3), .REPEAT_TICKS(0), .ACTIVE_LOW(8'h00)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_i(in_b), .out_o(out_b), .rise_o(rise_b),
        .fall_o(fall_b), .hold_o(hold_b), .hold_pulse_o(hp_b), .sample_tick_o(tick_b)
    );

    function automatic ev_t mk(input int c, input logic [7:0] r, input logic [7:0] f,
                               input logic [7:0] p, input logic [7:0] o, input logic [7:0] h);
        mk = {c, r, f, p, o, h};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cmp_ev(input string name, input ev_t act, input ev_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got cyc=%0d rise=%h fall=%h hp=%h out=%h hold=%h, expected cyc=%0d rise=%h fall=%h hp=%h out=%h hold=%h",
                     name, act.cyc, act.rise, act.fall, act.hp, act.out, act.hold,
                     exp.cyc, exp.rise, exp.fall, exp.hp, exp.out, exp.hold);
        end
    endtask

    always @(negedge clk) begin : mon_a
        ev_t act;
        act = {cyc, rise_a, fall_a, hp_a, out_a, hold_a};
        if ((rise_a | fall_a | hp_a) != 8'h00) begin
            if (qa.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL dut_a_event: unexpected cyc=%0d rise=%h fall=%h hp=%h",
                         cyc, rise_a, fall_a, hp_a);
            end else begin
                cmp_ev("dut_a_event", act, qa.pop_front());
            end
        end
    end

    always @(negedge clk) begin : mon_b
        ev_t act;
        act = {cyc, rise_b, fall_b, hp_b, out_b, hold_b};
        if ((rise_b | fall_b | hp_b) != 8'h00) begin
            if (qb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL dut_b_event: unexpected cyc=%0d rise=%h fall=%h hp=%h",
                         cyc, rise_b, fall_b, hp_b);
            end else begin
                cmp_ev("dut_b_event", act, qb.pop_front());
            end
        end
    end

    task automatic drive_a(input logic [7:0] lvl);
        in_a = lvl ^ 8'h01;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Logical press of mask m on A for d cycles (d >= 8), repeat every 2 ticks after hold.
    task automatic press_a(input logic [7:0] m, input int d);
        int e0;
        e0 = cyc;
        drive_a(m);
        qa.push_back(mk(e0 + 6, m, 8'h00, 8'h00, m, 8'h00));
        for (int t = e0 + 8; t < e0 + d + 6; t += 2) begin
            qa.push_back(mk(t, 8'h00, 8'h00, m, m, m));
        end
        qa.push_back(mk(e0 + d + 6, 8'h00, m, 8'h00, 8'h00, 8'h00));
        wait_neg(5);
        chk("latency_not_early", out_a, 8'h00);
        wait_neg(2);
        chk("rise_one_cycle", rise_a, 8'h00);
        chk("out_after_rise", out_a, m);
        wait_neg(d - 7);
        drive_a(8'h00);
        wait_neg(10);
        chk("hold_after_release", hold_a, 8'h00);
        chk("out_after_release", out_a, 8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  e0;
        int  c0;
        bit  found;
        rst_n = 1'b1;
        drive_a(8'h00);
        in_b = 8'h00;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_out", out_a, 8'h00);
        chk("reset_hold", hold_a, 8'h00);
        chk("reset_tick", tick_a, 1'b0);
        wait_neg(3);
        rst_n = 1'b1;
        wait_neg(5);
        chk("tick_rate1", tick_a, 1'b1);

        // Active-low channel 0 press: latency, hold, repeat, fall.
        press_a(8'h01, 10);
        // Channel 3: release timed so the fall lands on a would-be repeat tick.
        press_a(8'h08, 12);

        // Glitch of 3 samples on channel 1 must never reach the output.
        drive_a(8'h02);
        wait_neg(3);
        drive_a(8'h00);
        for (int i = 0; i < 10; i++) begin
            wait_neg(1);
            chk("glitch_out", out_a, 8'h00);
        end

        // All channels at once, then reset mid-hold.
        e0 = cyc;
        drive_a(8'hFF);
        qa.push_back(mk(e0 + 6, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00));
        qa.push_back(mk(e0 + 8, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF));
        qa.push_back(mk(e0 + 10, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF));
        wait_neg(9);
        chk("all_hold", hold_a, 8'hFF);
        wait_neg(2);
        rst_n = 1'b0;
        drive_a(8'h00);
        #1;
        chk("async_rst_out", out_a, 8'h00);
        chk("async_rst_hold", hold_a, 8'h00);
        chk("async_rst_pulses", {rise_a, fall_a, hp_a}, 24'h0);
        chk("async_rst_tick", tick_a, 1'b0);
        wait_neg(3);
        rst_n = 1'b1;
        wait_neg(20);
        chk("a_queue_drained", qa.size(), 0);

        // B: align to the prescaler, then a 40-cycle press on channel 2.
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            wait_neg(1);
            found = (tick_b === 1'b1);
        end
        chk("b_tick_found", found, 1'b1);
        if (found) begin
            wait_neg(1);
            chk("b_tick_low", tick_b, 1'b0);
            wait_neg(3);
            chk("b_tick_period", tick_b, 1'b1);
            c0 = cyc;
            in_b = 8'h04;
            qb.push_back(mk(c0 + 17, 8'h04, 8'h00, 8'h00, 8'h04, 8'h00));
            qb.push_back(mk(c0 + 29, 8'h00, 8'h00, 8'h04, 8'h04, 8'h04));
            qb.push_back(mk(c0 + 57, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00));
            wait_neg(28);
            chk("b_no_hold_early", hold_b, 8'h00);
            wait_neg(12);
            in_b = 8'h00;
            wait_neg(16);
            chk("b_hold_before_fall", hold_b, 8'h04);
            wait_neg(10);
            chk("b_queue_drained", qb.size(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
